// File: rtl/led_blink_pkg.sv
// Shared types for the multi-rate LED blinker: channel modes, burst FSM states
// and the rate-select width derivation.
// Pure definitions, no logic, no latency, no backpressure.
package led_blink_pkg;

    // Per-channel output mode, as driven on i_mode
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    // Burst sequencer state per channel
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Rate index width; a single-rate build still carries a 1-bit select
    function automatic int sel_width(input int n_rate);
        return (n_rate > 1) ? $clog2(n_rate) : 1;
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running half-period divider: toggle inverts every DIV cycles.
// Latency: toggle registered; rise/fall flag the edge on which toggle will change.
// Backpressure: none, runs every cycle.
// Ports: clk, rst_n (async active-low), toggle (square wave, period 2*DIV),
//        rise/fall (high in the cycle whose closing edge flips toggle 0->1 / 1->0).
module blink_prescaler
    import led_blink_pkg::*;
#(
    parameter int               CNT_W = 32,
    parameter logic [CNT_W-1:0] DIV   = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic toggle,
    output logic rise,
    output logic fall
);

    logic [CNT_W-1:0] cnt;
    logic             tc;

    assign tc = (cnt == DIV - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            toggle <= 1'b0;
        end else if (tc) begin
            cnt    <= '0;
            toggle <= ~toggle;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Pulses are decoded from the terminal count so that logic sampling them
    // acts on the very edge where toggle changes. Qualified with reset so that a
    // DIV of 1 (terminal count held at cnt==0) shows no pulse while in reset.
    assign rise = rst_n & tc & ~toggle;
    assign fall = rst_n & tc & toggle;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver: OFF/ON/BLINK/BURST per channel from shared prescalers.
// Latency: o_led one cycle after inputs/toggles; o_busy follows the burst FSM state.
// Backpressure: none; i_start is level-sampled and ignored while a burst is active.
// Ports: i_clock, i_reset_n (async active-low), i_enable (output gate),
//        i_rate_sel/i_mode per channel, i_burst_len (shared), i_start per channel,
//        o_led (registered drive), o_busy (channel in ARMED or RUN).
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int                      N_RATE    = 4,
    parameter int                      CNT_W     = 32,
    parameter logic [N_RATE*CNT_W-1:0] DIV_TABLE = {32'd24000, 32'd2500, 32'd500, 32'd250},
    parameter int                      N_LED     = 2,
    parameter int                      BURST_W   = 4
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset_n,
    input  logic                                 i_enable,
    input  logic [N_LED*sel_width(N_RATE)-1:0]   i_rate_sel,
    input  logic [N_LED*2-1:0]                   i_mode,
    input  logic [BURST_W-1:0]                   i_burst_len,
    input  logic [N_LED-1:0]                     i_start,
    output logic [N_LED-1:0]                     o_led,
    output logic [N_LED-1:0]                     o_busy
);

    localparam int SEL_W = sel_width(N_RATE);

    logic [N_RATE-1:0] toggle;
    logic [N_RATE-1:0] rise;
    logic [N_RATE-1:0] fall;

    for (genvar r = 0; r < N_RATE; r++) begin : g_rate
        blink_prescaler #(
            .CNT_W (CNT_W),
            .DIV   (DIV_TABLE[r*CNT_W +: CNT_W])
        ) u_prescaler (
            .clk    (i_clock),
            .rst_n  (i_reset_n),
            .toggle (toggle[r]),
            .rise   (rise[r]),
            .fall   (fall[r])
        );
    end

    for (genvar c = 0; c < N_LED; c++) begin : g_ch
        logic [SEL_W-1:0]   sel_raw;
        logic [SEL_W-1:0]   sel;
        mode_t              mode;
        state_t             state;
        state_t             state_nxt;
        logic [BURST_W-1:0] per_cnt;
        logic [BURST_W-1:0] per_cnt_nxt;
        logic [BURST_W-1:0] len_q;
        logic [BURST_W-1:0] len_nxt;
        logic               f;
        logic               led_q;

        assign sel_raw = i_rate_sel[c*SEL_W +: SEL_W];
        // Out-of-range selects fall back to the slowest populated entry
        assign sel     = (int'(sel_raw) >= N_RATE) ? SEL_W'(N_RATE - 1) : sel_raw;
        assign mode    = mode_t'(i_mode[c*2 +: 2]);

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                state   <= ST_IDLE;
                per_cnt <= '0;
                len_q   <= '0;
                led_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                per_cnt <= per_cnt_nxt;
                len_q   <= len_nxt;
                led_q   <= i_enable & f;
            end
        end

        always_comb begin
            state_nxt   = state;
            per_cnt_nxt = per_cnt;
            len_nxt     = len_q;
            f           = 1'b0;

            case (state)
                ST_IDLE: begin
                    if (mode == MODE_BURST && i_start[c] && i_burst_len != '0) begin
                        state_nxt   = ST_ARMED;
                        len_nxt     = i_burst_len;
                        per_cnt_nxt = '0;
                    end
                end
                // Wait for a rising toggle so every burst starts with a full high phase
                ST_ARMED: begin
                    if (rise[sel]) begin
                        state_nxt = ST_RUN;
                    end
                end
                // A period completes on its falling toggle; the rate may change
                // mid-burst and the count carries over
                ST_RUN: begin
                    if (fall[sel]) begin
                        per_cnt_nxt = per_cnt + BURST_W'(1);
                        if (per_cnt_nxt == len_q) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase

            // Leaving BURST mode abandons any burst in progress
            if (mode != MODE_BURST) begin
                state_nxt = ST_IDLE;
            end

            case (mode)
                MODE_OFF:   f = 1'b0;
                MODE_ON:    f = 1'b1;
                MODE_BLINK: f = toggle[sel];
                MODE_BURST: f = (state == ST_RUN) & toggle[sel];
                default:    f = 1'b0;
            endcase
        end

        assign o_led[c]  = led_q;
        assign o_busy[c] = (state != ST_IDLE);
    end

endmodule
